// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 800x600@60 raster timing generator.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 40;
   localparam int DEF_H_SYNC   = 128;
   localparam int DEF_H_BP     = 88;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 4;
   localparam int DEF_V_BP     = 23;
   localparam int DEF_PIX_LAT  = 2;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int HW = 11;
   localparam int VW = 10;

   // Delay-line entry layout: {vis, hs, vs}
   localparam int DL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } vga_state_e;

endpackage

// File: rtl/vga_delay_line.sv
// Registered shift register with synchronous reset to a fixed value.
module vga_delay_line #(
   parameter int             WIDTH     = 3,
   parameter int             DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: frame FSM, h/v counters, pixel requests, and sync/blank
// aligned to the pixel-source latency before the DAC output register.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   PIX_LAT  = DEF_PIX_LAT
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   output logic          REQ_VALID,
   output logic [10:0]   REQ_X,
   output logic [9:0]    REQ_Y,
   input  logic [7:0]    PIX_R,
   input  logic [7:0]    PIX_G,
   input  logic [7:0]    PIX_B,
   output logic          FRAME_START,
   output logic          RUNNING,
   output logic [7:0]    VGA_R,
   output logic [7:0]    VGA_G,
   output logic [7:0]    VGA_B,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_BLANK_n,
   output logic          VGA_SYNC_n
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
   localparam logic [HW-1:0] H_VISEND = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_VISEND = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   vga_state_e    state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          req_valid_q, req_valid_d;
   logic [HW-1:0] req_x_q, req_x_d;
   logic [VW-1:0] req_y_q, req_y_d;
   logic          frame_start_q, frame_start_d;
   logic          running_q, running_d;
   logic [7:0]    vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
   logic          vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
   logic          blank_n_q, blank_n_d;

   logic            at_end, issue, vis, hs, vs;
   logic [DL_W-1:0] dl_out;

   // Counters describe the position issued on REQ_* after the same edge.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      at_end  = (h_q == H_LAST) && (v_q == V_LAST);
      case (state_q)
         ST_IDLE: begin
            h_d = '0;
            v_d = '0;
            if (EN) state_d = ST_RUN;
            else    state_d = ST_IDLE;
         end
         ST_RUN, ST_DRAIN: begin
            if (at_end) begin
               h_d = '0;
               v_d = '0;
               state_d = EN ? ST_RUN : ST_IDLE;
            end else begin
               if (h_q == H_LAST) begin
                  h_d = '0;
                  v_d = v_q + VW'(1);
               end else begin
                  h_d = h_q + HW'(1);
                  v_d = v_q;
               end
               state_d = EN ? ST_RUN : ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
         end
      endcase

      issue = (state_d != ST_IDLE);
      vis   = issue && (h_d < H_VISEND) && (v_d < V_VISEND);
      hs    = issue && (h_d >= HS_BEG) && (h_d < HS_END);
      vs    = issue && (v_d >= VS_BEG) && (v_d < VS_END);

      req_valid_d   = vis;
      req_x_d       = vis ? h_d : req_x_q;
      req_y_d       = vis ? v_d : req_y_q;
      frame_start_d = issue && (h_d == '0) && (v_d == '0);
      running_d     = issue;

      // dl_out is the decode from PIX_LAT edges ago, matching today's PIX_*.
      vga_r_d   = dl_out[2] ? PIX_R : 8'h00;
      vga_g_d   = dl_out[2] ? PIX_G : 8'h00;
      vga_b_d   = dl_out[2] ? PIX_B : 8'h00;
      blank_n_d = dl_out[2];
      vga_hs_d  = dl_out[1] ? HS_POL : ~HS_POL;
      vga_vs_d  = dl_out[0] ? VS_POL : ~VS_POL;
   end

   vga_delay_line #(
      .WIDTH     (DL_W),
      .DEPTH     (PIX_LAT),
      .RESET_VAL (3'b000)
   ) u_align (
      .clk  (CLK),
      .rst  (RST),
      .din  ({vis, hs, vs}),
      .dout (dl_out)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         h_q           <= '0;
         v_q           <= '0;
         req_valid_q   <= 1'b0;
         req_x_q       <= '0;
         req_y_q       <= '0;
         frame_start_q <= 1'b0;
         running_q     <= 1'b0;
         vga_r_q       <= 8'h00;
         vga_g_q       <= 8'h00;
         vga_b_q       <= 8'h00;
         blank_n_q     <= 1'b0;
         vga_hs_q      <= ~HS_POL;
         vga_vs_q      <= ~VS_POL;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         req_valid_q   <= req_valid_d;
         req_x_q       <= req_x_d;
         req_y_q       <= req_y_d;
         frame_start_q <= frame_start_d;
         running_q     <= running_d;
         vga_r_q       <= vga_r_d;
         vga_g_q       <= vga_g_d;
         vga_b_q       <= vga_b_d;
         blank_n_q     <= blank_n_d;
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
      end
   end

   assign REQ_VALID   = req_valid_q;
   assign REQ_X       = req_x_q;
   assign REQ_Y       = req_y_q;
   assign FRAME_START = frame_start_q;
   assign RUNNING     = running_q;
   assign VGA_R       = vga_r_q;
   assign VGA_G       = vga_g_q;
   assign VGA_B       = vga_b_q;
   assign VGA_HS      = vga_hs_q;
   assign VGA_VS      = vga_vs_q;
   assign VGA_BLANK_n = blank_n_q;
   assign VGA_SYNC_n  = 1'b0;

endmodule
